regfile_mp: RTL and testbench

- Parametrised multi-read-port register file for the pipelined core. It replaces the fixed two-read-port file.
- Depth is 2**R. Register 0 reads as zero and is never written.
- Adds the following:
  - asynchronous reset of all entries
  - configurable same-cycle write-to-read bypass
  - per-register busy scoreboard bits for hazard detection
  - sequential bulk-clear state machine used on pipeline flush or context reset

---
 rtl/regfile_mp.sv | 123 ++++++++++++
 tb/tb_regfile_mp.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-read-port register file with per-register busy scoreboard and a
// sequential bulk-clear FSM used on pipeline flush or context reset.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | normal operation: writes, scoreboard marks, live reads
// S_CLEAR | zeroing entries 1..2**R-1, one per cycle; reads return 0
// S_DONE  | one-cycle completion pulse on clr_done; reads return 0
module regfile_mp #(
    parameter int N      = 16,
    parameter int R      = 3,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we3,
    input  logic [R-1:0]     wa3,
    input  logic [N-1:0]     wd3,
    input  logic [NRD*R-1:0] ra,
    output logic [NRD*N-1:0] rd,
    output logic [NRD-1:0]   busy,
    input  logic             mark_we,
    input  logic [R-1:0]     mark_addr,
    input  logic             clr_req,
    output logic             clr_active,
    output logic             clr_done
);

    localparam int DEPTH = 2**R;
    localparam logic [R-1:0] LAST_IDX = '1;
    localparam logic [R-1:0] FIRST_IDX = R'(1);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [R-1:0]     idx;
    logic [N-1:0]     rf [DEPTH];
    logic [DEPTH-1:0] busy_q;

    logic wr_ok;
    logic mark_ok;

    assign wr_ok   = we3 && (wa3 != '0);
    assign mark_ok = mark_we && (mark_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        clr_active = 1'b0;
        clr_done   = 1'b0;
        case (state)
            S_IDLE: begin
                if (clr_req) state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                clr_active = 1'b1;
                if (idx == LAST_IDX) state_nxt = S_DONE;
            end
            S_DONE: begin
                clr_active = 1'b1;
                clr_done   = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++) rf[j] <= '0;
            busy_q <= '0;
            idx    <= FIRST_IDX;
        end else begin
            case (state)
                S_IDLE: begin
                    if (wr_ok) rf[wa3] <= wd3;
                    if (clr_req) begin
                        busy_q <= '0;
                        idx    <= FIRST_IDX;
                    end else begin
                        // Mark is applied after the write so a same-edge mark wins.
                        if (wr_ok)   busy_q[wa3]       <= 1'b0;
                        if (mark_ok) busy_q[mark_addr] <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    rf[idx] <= '0;
                    idx     <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd   = '0;
        busy = '0;
        if (state == S_IDLE) begin
            for (int i = 0; i < NRD; i++) begin
                if (ra[i*R +: R] != '0) begin
                    if ((BYPASS != 0) && we3 && (wa3 == ra[i*R +: R])) begin
                        rd[i*N +: N] = wd3;
                        busy[i]      = 1'b0;
                    end else begin
                        rd[i*N +: N] = rf[ra[i*R +: R]];
                        busy[i]      = busy_q[ra[i*R +: R]];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one DUT with bypass, one without, sharing stimulus.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic        we3;
    logic [2:0]  wa3;
    logic [15:0] wd3;
    logic [5:0]  ra;
    logic        mark_we;
    logic [2:0]  mark_addr;
    logic        clr_req;

    logic [31:0] rd,    rd_nb;
    logic [1:0]  busy,  busy_nb;
    logic        clr_active, clr_active_nb;
    logic        clr_done,   clr_done_nb;

    int vectors;
    int miscompares;

    regfile_mp #(.N(16), .R(3), .NRD(2), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra(ra), .rd(rd), .busy(busy), .mark_we(mark_we), .mark_addr(mark_addr),
        .clr_req(clr_req), .clr_active(clr_active), .clr_done(clr_done)
    );

    regfile_mp #(.N(16), .R(3), .NRD(2), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra(ra), .rd(rd_nb), .busy(busy_nb), .mark_we(mark_we), .mark_addr(mark_addr),
        .clr_req(clr_req), .clr_active(clr_active_nb), .clr_done(clr_done_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ra    = {3'd5, 3'd1};
        repeat (2) @(negedge clk);
        vectors++;
        if (rd !== 32'h0 || busy !== 2'b00 || clr_active !== 1'b0 || clr_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: rd=%h busy=%b act=%b done=%b, want 0/00/0/0", rd, busy, clr_active, clr_done);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (rd !== 32'h0 || busy !== 2'b00 || rd_nb !== 32'h0 || busy_nb !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_release: rd=%h busy=%b rd_nb=%h busy_nb=%b, want zeros", rd, busy, rd_nb, busy_nb);
        end
    endtask

    task automatic test_write_bypass();
        @(negedge clk);
        we3 = 1'b1; wa3 = 3'd3; wd3 = 16'hBEEF; ra = {3'd0, 3'd3};
        #1;
        vectors++;
        if (rd !== 32'h0000_BEEF) begin
            miscompares++;
            $display("FAIL bypass_same_cycle: rd=%h, want 0000beef", rd);
        end
        vectors++;
        if (rd_nb !== 32'h0000_0000) begin
            miscompares++;
            $display("FAIL nobypass_same_cycle: rd_nb=%h, want 00000000", rd_nb);
        end
        tick();
        we3 = 1'b0;
        #1;
        vectors++;
        if (rd !== 32'h0000_BEEF || rd_nb !== 32'h0000_BEEF) begin
            miscompares++;
            $display("FAIL write_after_edge: rd=%h rd_nb=%h, want 0000beef both", rd, rd_nb);
        end
    endtask

    task automatic test_reg0();
        @(negedge clk);
        we3 = 1'b1; wa3 = 3'd0; wd3 = 16'hFFFF;
        mark_we = 1'b1; mark_addr = 3'd0; ra = {3'd0, 3'd0};
        #1;
        vectors++;
        if (rd !== 32'h0 || busy !== 2'b00) begin
            miscompares++;
            $display("FAIL reg0_same_cycle: rd=%h busy=%b, want 0/00", rd, busy);
        end
        tick();
        we3 = 1'b0; mark_we = 1'b0;
        #1;
        vectors++;
        if (rd !== 32'h0 || busy !== 2'b00 || rd_nb !== 32'h0 || busy_nb !== 2'b00) begin
            miscompares++;
            $display("FAIL reg0_after_edge: rd=%h busy=%b rd_nb=%h busy_nb=%b, want zeros", rd, busy, rd_nb, busy_nb);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        mark_we = 1'b1; mark_addr = 3'd6;
        tick();
        mark_we = 1'b0; ra = {3'd6, 3'd3};
        #1;
        vectors++;
        if (busy !== 2'b10 || busy_nb !== 2'b10 || rd !== 32'h0000_BEEF) begin
            miscompares++;
            $display("FAIL mark_set: busy=%b busy_nb=%b rd=%h, want 10/10/0000beef", busy, busy_nb, rd);
        end
        @(negedge clk);
        we3 = 1'b1; wa3 = 3'd6; wd3 = 16'h0042;
        #1;
        vectors++;
        if (busy[1] !== 1'b0 || rd[31:16] !== 16'h0042) begin
            miscompares++;
            $display("FAIL sb_bypass: busy1=%b rd1=%h, want 0/0042", busy[1], rd[31:16]);
        end
        vectors++;
        if (busy_nb[1] !== 1'b1 || rd_nb[31:16] !== 16'h0000) begin
            miscompares++;
            $display("FAIL sb_nobypass: busy1=%b rd1=%h, want 1/0000", busy_nb[1], rd_nb[31:16]);
        end
        tick();
        we3 = 1'b0;
        #1;
        vectors++;
        if (busy !== 2'b00 || rd[31:16] !== 16'h0042 || busy_nb !== 2'b00 || rd_nb[31:16] !== 16'h0042) begin
            miscompares++;
            $display("FAIL sb_write_clears: busy=%b rd1=%h busy_nb=%b rd1_nb=%h, want 00/0042", busy, rd[31:16], busy_nb, rd_nb[31:16]);
        end
        @(negedge clk);
        we3 = 1'b1; wa3 = 3'd6; wd3 = 16'h0077;
        mark_we = 1'b1; mark_addr = 3'd6;
        tick();
        we3 = 1'b0; mark_we = 1'b0;
        #1;
        vectors++;
        if (busy[1] !== 1'b1 || rd[31:16] !== 16'h0077 || busy_nb[1] !== 1'b1 || rd_nb[31:16] !== 16'h0077) begin
            miscompares++;
            $display("FAIL sb_mark_wins: busy1=%b rd1=%h busy1_nb=%b rd1_nb=%h, want 1/0077", busy[1], rd[31:16], busy_nb[1], rd_nb[31:16]);
        end
    endtask

    task automatic test_bulk_clear();
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            we3 = 1'b1; wa3 = 3'(i); wd3 = 16'(16'h1111 * i);
        end
        @(negedge clk);
        we3 = 1'b0; mark_we = 1'b1; mark_addr = 3'd5;
        tick();
        mark_we = 1'b0; ra = {3'd7, 3'd5};
        #1;
        vectors++;
        if (rd !== 32'h7777_5555 || busy !== 2'b01) begin
            miscompares++;
            $display("FAIL fill: rd=%h busy=%b, want 77775555/01", rd, busy);
        end
        @(negedge clk);
        clr_req = 1'b1; mark_we = 1'b1; mark_addr = 3'd7;
        tick();
        clr_req = 1'b0; mark_we = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 3) begin
                we3 = 1'b1; wa3 = 3'd1; wd3 = 16'hABCD;
                mark_we = 1'b1; mark_addr = 3'd1; clr_req = 1'b1;
            end else begin
                we3 = 1'b0; mark_we = 1'b0; clr_req = 1'b0;
            end
            #1;
            vectors++;
            if (clr_active !== 1'b1 || clr_done !== (k == 8) || rd !== 32'h0 || busy !== 2'b00) begin
                miscompares++;
                $display("FAIL clear_cycle%0d: act=%b done=%b rd=%h busy=%b, want 1/%0d/0/00", k, clr_active, clr_done, rd, busy, (k == 8));
            end
            tick();
        end
        we3 = 1'b0; mark_we = 1'b0; clr_req = 1'b0;
        #1;
        vectors++;
        if (clr_active !== 1'b0 || clr_done !== 1'b0 || clr_active_nb !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_end: act=%b done=%b act_nb=%b, want 0/0/0", clr_active, clr_done, clr_active_nb);
        end
        for (int i = 1; i < 8; i++) begin
            ra = {3'(i), 3'(i)};
            #1;
            vectors++;
            if (rd !== 32'h0 || busy !== 2'b00 || rd_nb !== 32'h0) begin
                miscompares++;
                $display("FAIL cleared_reg%0d: rd=%h busy=%b rd_nb=%h, want zeros", i, rd, busy, rd_nb);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        @(negedge clk);
        we3 = 1'b1; wa3 = 3'd2; wd3 = 16'h2222;
        tick();
        wa3 = 3'd6; wd3 = 16'h6666; mark_we = 1'b1; mark_addr = 3'd6;
        tick();
        we3 = 1'b0; mark_we = 1'b0; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        tick();
        ra = {3'd6, 3'd2};
        rst_n = 1'b0;
        #1;
        vectors++;
        if (clr_active !== 1'b0 || clr_done !== 1'b0) begin
            miscompares++;
            $display("FAIL midclear_flags: act=%b done=%b, want 0/0", clr_active, clr_done);
        end
        vectors++;
        if (rd !== 32'h0 || busy !== 2'b00) begin
            miscompares++;
            $display("FAIL midclear_data: rd=%h busy=%b, want 0/00", rd, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        we3 = 1'b1; wa3 = 3'd6; wd3 = 16'h1234;
        #1;
        vectors++;
        if (rd !== 32'h1234_0000 || rd_nb !== 32'h0) begin
            miscompares++;
            $display("FAIL post_reset_bypass: rd=%h rd_nb=%h, want 12340000/00000000", rd, rd_nb);
        end
        tick();
        we3 = 1'b0;
        #1;
        vectors++;
        if (rd !== 32'h1234_0000 || rd_nb !== 32'h1234_0000 || busy !== 2'b00) begin
            miscompares++;
            $display("FAIL post_reset_write: rd=%h rd_nb=%h busy=%b, want 12340000 both/00", rd, rd_nb, busy);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n     = 1'b0;
        we3       = 1'b0;
        wa3       = '0;
        wd3       = '0;
        ra        = '0;
        mark_we   = 1'b0;
        mark_addr = '0;
        clr_req   = 1'b0;
        test_reset();
        test_write_bypass();
        test_reg0();
        test_scoreboard();
        test_bulk_clear();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
